spi_shift_engine: RTL and testbench
===================================

// Module: spi_shift_engine
// PURPOSE
//  Parametrised, clocked full-duplex SPI data shifter: parallel-loads a TX word, shifts it out
//  serially one bit per shift strobe while capturing serial RX bits, then presents the RX word.
//  Has a bit counter, selectable bit order, abort, and val/rdy handshakes on both parallel sides.
//  Sits between the SPI edge/strobe logic (drives shift_en, sin, sout) and the word-level
//  controller (load_*/recv_* interfaces).
// PARAMETERS
//  BITWIDTH   32  word length in bits; legal range 2..64
//  MSB_FIRST  1   1: shift out shreg[BITWIDTH-1], sin enters at bit 0; 0: shift out shreg[0], sin enters at MSB
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  reset      in   1         asynchronous, active-high reset
//  load_val   in   1         TX word valid
//  load_rdy   out  1         engine idle, can accept TX word
//  load_data  in   BITWIDTH  TX word
//  shift_en   in   1         one-cycle strobe per SPI bit
//  sin        in   1         serial RX bit, sampled on the clk edge where shift_en=1
//  sout       out  1         serial TX bit currently presented
//  abort      in   1         synchronous cancel of an in-progress transfer
//  recv_val   out  1         RX word valid
//  recv_rdy   in   1         consumer accepts RX word
//  recv_data  out  BITWIDTH  RX word
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  States: IDLE, SHIFT, HOLD. Registers: shreg[BITWIDTH-1:0], cnt[$clog2(BITWIDTH)-1:0], recv_data.
//  Reset (async, while asserted and after): state=IDLE, shreg=0, cnt=0, recv_data=0;
//   so load_rdy=1, recv_val=0, busy=0, sout=0. Reset mid-transfer discards the word, no recv_val.
//  Outputs decoded from state: load_rdy=(IDLE), recv_val=(HOLD), busy=(state!=IDLE).
//  sout = MSB_FIRST ? shreg[BITWIDTH-1] : shreg[0]; combinational from register, valid in all states.
//  IDLE: load_val&load_rdy -> shreg<=load_data, cnt<=0, ->SHIFT (1st bit on sout next cycle).
//   shift_en, abort ignored in IDLE.
//  SHIFT: shift_en=1 -> MSB_FIRST: shreg<={shreg[BITWIDTH-2:0],sin}; else shreg<={sin,shreg[BITWIDTH-1:1]};
//   cnt<=cnt+1. shift_en=0 -> hold shreg/cnt (gaps of any length legal).
//   shift_en=1 with cnt==BITWIDTH-1 -> recv_data<=shifted value (incl. this sin), cnt<=0, ->HOLD.
//   abort=1 -> IDLE, cnt<=0, shreg unchanged, recv_data unchanged; abort wins over shift_en same cycle.
//   load_val ignored (load_rdy=0).
//  HOLD: recv_data stable; recv_rdy=1 -> IDLE next cycle. shift_en, load_val ignored.
//   abort=1 -> IDLE, word dropped (recv_val deasserts); abort wins over recv_rdy.
//  Latency: load accept -> recv_val = (BITWIDTH shift_en strobes) + 1 cycle minimum.
//  Back-to-back: after recv fire, load accepted earliest the following cycle (IDLE).
//  recv_val never drops without handshake except via abort/reset; recv_data never changes while recv_val=1.
// TESTING
//  1) BITWIDTH=8, MSB_FIRST=1: load 0xA5, 8 consecutive shift_en, sin bits 0,0,1,1,1,1,0,0 ->
//     sout 1,0,1,0,0,1,0,1; recv_val=1 one cycle after 8th strobe, recv_data=0x3C.
//  2) MSB_FIRST=0, load 0xA5, sin 0,0,1,1,1,1,0,0 -> sout 1,0,1,0,0,1,0,1 (LSB first); recv_data=0x3C.
//  3) recv_rdy=0 for 5 cycles in HOLD with shift_en/load_val toggling -> recv_data=0x3C stable,
//     load_rdy=0; recv_rdy=1 -> IDLE, load_rdy=1 next cycle.
//  4) shift_en with random gaps (1..4 idle cycles) -> identical sout sequence and recv_data as 1).
//  5) abort after 3 bits (same cycle as shift_en) -> IDLE next cycle, recv_val never 1, cnt restarts
//     at 0 on next load (next 8-bit transfer completes after exactly 8 strobes).
//  6) Assert reset asynchronously mid-SHIFT (between clk edges) -> load_rdy=1, busy=0, sout=0,
//     recv_data=0 immediately; normal transfer works after release.

Source files
------------

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI word shifter: parallel-loads a TX word, shifts it out one bit per
// shift_en strobe while capturing sin, then holds the received word until it is taken.
module spi_shift_engine #(
   parameter int BITWIDTH  = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_val,
   output logic                load_rdy,
   input  logic [BITWIDTH-1:0] load_data,
   input  logic                shift_en,
   input  logic                sin,
   output logic                sout,
   input  logic                abort,
   output logic                recv_val,
   input  logic                recv_rdy,
   output logic [BITWIDTH-1:0] recv_data,
   output logic                busy,
   output logic [1:0]          state_dbg
);

   localparam int CNT_W = $clog2(BITWIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              state;
   logic [BITWIDTH-1:0] shreg;
   logic [CNT_W-1:0]    cnt;
   logic [BITWIDTH-1:0] shifted;

   // Handshakes: a word moves on a rising edge where val and rdy are both 1; the
   // producer holds val (and data) until that edge, and rdy never depends on val.
   assign load_rdy  = (state == IDLE);
   assign recv_val  = (state == HOLD);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign sout      = MSB_FIRST ? shreg[BITWIDTH-1] : shreg[0];

   always_comb begin
      shifted = shreg;
      if (MSB_FIRST) shifted = {shreg[BITWIDTH-2:0], sin};
      else           shifted = {sin, shreg[BITWIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         recv_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_val) begin
                  shreg <= load_data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // abort leaves shreg as-is so sout keeps showing the last presented bit
               if (abort) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (shift_en) begin
                  shreg <= shifted;
                  if (cnt == LAST_BIT) begin
                     recv_data <= shifted;
                     cnt       <= '0;
                     state     <= HOLD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (abort || recv_rdy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: one MSB-first and one LSB-first 8-bit instance share stimulus;
// fixed vectors, corner sequences (hold, gaps, abort, async reset) and random transfers.
module tb_spi_shift_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_val;
   logic [7:0] load_data;
   logic       shift_en;
   logic       sin;
   logic       abort;
   logic       recv_rdy;

   logic       load_rdy_m, sout_m, recv_val_m, busy_m;
   logic       load_rdy_l, sout_l, recv_val_l, busy_l;
   logic [7:0] recv_data_m, recv_data_l;
   logic [1:0] state_dbg_m, state_dbg_l;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] seq;    // bit i is the sin value for strobe i
      logic [7:0] exp_m;
      logic [7:0] exp_l;
   } vec_t;
   vec_t vecs[5];

   spi_shift_engine #(.BITWIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .load_val(load_val), .load_rdy(load_rdy_m),
      .load_data(load_data), .shift_en(shift_en), .sin(sin), .sout(sout_m),
      .abort(abort), .recv_val(recv_val_m), .recv_rdy(recv_rdy),
      .recv_data(recv_data_m), .busy(busy_m), .state_dbg(state_dbg_m)
   );

   spi_shift_engine #(.BITWIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .load_val(load_val), .load_rdy(load_rdy_l),
      .load_data(load_data), .shift_en(shift_en), .sin(sin), .sout(sout_l),
      .abort(abort), .recv_val(recv_val_l), .recv_rdy(recv_rdy),
      .recv_data(recv_data_l), .busy(busy_l), .state_dbg(state_dbg_l)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Bit i of the serial output stream.
   function automatic logic tx_bit(input logic [7:0] word, input int i, input bit msb);
      int pos;
      pos = msb ? 7 - i : i;
      return logic'((word >> pos) & 8'd1);
   endfunction

   // Received word: the first bit in ends up at the far end from where bits enter.
   function automatic logic [7:0] model_rx(input logic [7:0] seq, input bit msb);
      int rx;
      rx = 0;
      for (int i = 0; i < 8; i++) begin
         if (msb) rx = rx * 2 + int'(seq[i]);
         else     rx = rx + (int'(seq[i]) << i);
      end
      return rx[7:0];
   endfunction

   // Called at a negedge with the engines idle; returns at a negedge with them idle again.
   task automatic do_transfer(input logic [7:0] tx, input logic [7:0] seq,
                              input logic [7:0] exp_m, input logic [7:0] exp_l,
                              input int min_gap, input int max_gap, input int hold_cyc,
                              input bit end_abort);
      int gap;
      check("load_rdy_idle", {30'd0, load_rdy_m, load_rdy_l}, 32'd3);
      load_val  = 1'b1;
      load_data = tx;
      @(negedge clk);
      load_val  = 1'b0;
      load_data = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         gap = $urandom_range(max_gap, min_gap);
         repeat (gap) begin
            check("sout_gap", {26'd0, sout_m, sout_l, recv_val_m, recv_val_l, busy_m, busy_l},
                  {26'd0, tx_bit(tx, i, 1'b1), tx_bit(tx, i, 1'b0), 4'b0011});
            @(negedge clk);
         end
         check("sout_bit", {26'd0, sout_m, sout_l, recv_val_m, recv_val_l, busy_m, busy_l},
               {26'd0, tx_bit(tx, i, 1'b1), tx_bit(tx, i, 1'b0), 4'b0011});
         shift_en = 1'b1;
         sin      = seq[i];
         @(negedge clk);
         shift_en = 1'b0;
         sin      = 1'($urandom);
      end
      check("recv_val_done", {28'd0, recv_val_m, recv_val_l, load_rdy_m, load_rdy_l}, 32'hC);
      check("recv_data_msb", {24'd0, recv_data_m}, {24'd0, exp_m});
      check("recv_data_lsb", {24'd0, recv_data_l}, {24'd0, exp_l});
      repeat (hold_cyc) begin
         shift_en  = 1'($urandom);
         load_val  = 1'($urandom);
         sin       = 1'($urandom);
         load_data = 8'($urandom);
         @(negedge clk);
         check("hold_stable", {12'd0, recv_val_m, recv_val_l, load_rdy_m, load_rdy_l,
                               recv_data_m, recv_data_l}, {12'd0, 4'hC, exp_m, exp_l});
      end
      shift_en = 1'b0;
      load_val = 1'b0;
      recv_rdy = 1'b1;
      abort    = end_abort;
      @(negedge clk);
      recv_rdy = 1'b0;
      abort    = 1'b0;
      check("after_recv", {26'd0, load_rdy_m, load_rdy_l, recv_val_m, recv_val_l, busy_m, busy_l},
            32'h30);
   endtask

   initial begin
      logic [7:0] tx, seq;
      vecs[0] = '{tx: 8'hA5, seq: 8'h3C, exp_m: 8'h3C, exp_l: 8'h3C};
      vecs[1] = '{tx: 8'hFF, seq: 8'hFF, exp_m: 8'hFF, exp_l: 8'hFF};
      vecs[2] = '{tx: 8'h01, seq: 8'h01, exp_m: 8'h80, exp_l: 8'h01};
      vecs[3] = '{tx: 8'h80, seq: 8'h80, exp_m: 8'h01, exp_l: 8'h80};
      vecs[4] = '{tx: 8'h00, seq: 8'h00, exp_m: 8'h00, exp_l: 8'h00};

      reset = 1'b1; load_val = 1'b0; load_data = 8'h00; shift_en = 1'b0;
      sin = 1'b0; abort = 1'b0; recv_rdy = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ctl", {26'd0, load_rdy_m, load_rdy_l, recv_val_m, recv_val_l, busy_m, busy_l},
            32'h30);
      check("reset_data", {14'd0, sout_m, sout_l, recv_data_m, recv_data_l}, 32'd0);
      check("reset_state", {28'd0, state_dbg_m, state_dbg_l}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 5; v++)
         do_transfer(vecs[v].tx, vecs[v].seq, vecs[v].exp_m, vecs[v].exp_l, 0, 0, 0, 1'b0);

      // Long hold with noise on ignored inputs, then strobes with gaps.
      do_transfer(8'hA5, 8'h3C, 8'h3C, 8'h3C, 0, 0, 5, 1'b0);
      do_transfer(8'hA5, 8'h3C, 8'h3C, 8'h3C, 1, 4, 0, 1'b0);

      // Abort on the third strobe: abort wins, shreg keeps two shifts (sout=1 on both).
      load_val = 1'b1; load_data = 8'hA5;
      @(negedge clk);
      load_val = 1'b0;
      for (int i = 0; i < 3; i++) begin
         shift_en = 1'b1; sin = 1'b0; abort = (i == 2);
         @(negedge clk);
         shift_en = 1'b0; abort = 1'b0;
      end
      check("abort_shift", {26'd0, load_rdy_m, load_rdy_l, recv_val_m, recv_val_l, busy_m, busy_l},
            32'h30);
      check("abort_sout", {30'd0, sout_m, sout_l}, 32'd3);
      do_transfer(8'h5A, 8'hF0, model_rx(8'hF0, 1'b1), model_rx(8'hF0, 1'b0), 0, 1, 0, 1'b0);

      // Abort in HOLD drops the word even with recv_rdy high.
      do_transfer(8'h3C, 8'h0F, model_rx(8'h0F, 1'b1), model_rx(8'h0F, 1'b0), 0, 0, 2, 1'b1);

      // Asynchronous reset between edges mid-transfer.
      load_val = 1'b1; load_data = 8'hFF;
      @(negedge clk);
      load_val = 1'b0;
      for (int i = 0; i < 3; i++) begin
         shift_en = 1'b1; sin = 1'b1;
         @(negedge clk);
         shift_en = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      check("async_reset_ctl", {26'd0, load_rdy_m, load_rdy_l, recv_val_m, recv_val_l, busy_m,
                                busy_l}, 32'h30);
      check("async_reset_data", {14'd0, sout_m, sout_l, recv_data_m, recv_data_l}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_transfer(8'hC3, 8'h96, model_rx(8'h96, 1'b1), model_rx(8'h96, 1'b0), 0, 2, 1, 1'b0);

      for (int r = 0; r < 20; r++) begin
         tx  = 8'($urandom);
         seq = 8'($urandom);
         do_transfer(tx, seq, model_rx(seq, 1'b1), model_rx(seq, 1'b0), 0, 4,
                     int'($urandom_range(3, 0)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
